// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 receiver and make/break decoder for the game's direction/space keys
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keys,
    output logic [4:0] key_press,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_E0, D_F0, D_E0F0} dec_state_t;

    logic          clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    logic          data_smp_q, data_smp_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    scan_code_q, scan_code_d;
    logic          scan_valid_q, scan_valid_d;
    logic          frame_err_q, frame_err_d;

    dec_state_t    dec_state_q, dec_state_d;
    logic [4:0]    keys_q, keys_d;
    logic [4:0]    key_press_q, key_press_d;

    // One-hot key bit for a completed code; extended flag selects the E0 page.
    function automatic logic [4:0] key_map(input logic ext, input logic [7:0] code);
        logic [4:0] m;
        m = 5'b00000;
        if (ext) begin
            case (code)
                8'h75:   m = 5'b00001;
                8'h6B:   m = 5'b00010;
                8'h74:   m = 5'b00100;
                8'h72:   m = 5'b01000;
                default: m = 5'b00000;
            endcase
        end else if (code == 8'h29) begin
            m = 5'b10000;
        end
        return m;
    endfunction

    // Glitch filter: the accepted level flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        fall_d     = filt_q & ~filt_d;
        data_smp_d = data_s2_q;
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        scan_code_d  = scan_code_q;
        scan_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        to_cnt_d     = (rx_state_q == RX_IDLE || fall_q) ? '0 : to_cnt_q + TW'(1);

        if (fall_q) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!data_smp_q) begin
                        rx_state_d = RX_DATA;
                        bit_cnt_d  = 3'd0;
                        par_d      = 1'b0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {data_smp_q, shift_q[7:1]};
                    par_d     = par_q ^ data_smp_q;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d      = par_q ^ data_smp_q;
                    rx_state_d = RX_STOP;
                end
                RX_STOP: begin
                    // par_q holds the XOR of data and parity bits; odd parity leaves it at 1.
                    if (data_smp_q && par_q) begin
                        scan_code_d  = shift_q;
                        scan_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                    bit_cnt_d  = 3'd0;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end else if (rx_state_q != RX_IDLE && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
            frame_err_d = 1'b1;
            rx_state_d  = RX_IDLE;
            bit_cnt_d   = 3'd0;
            to_cnt_d    = '0;
        end
    end

    always_comb begin
        logic [4:0] m;
        dec_state_d = dec_state_q;
        keys_d      = keys_q;
        key_press_d = 5'b00000;
        m           = 5'b00000;
        if (scan_valid_q) begin
            case (dec_state_q)
                D_IDLE: begin
                    if (scan_code_q == 8'hE0) begin
                        dec_state_d = D_E0;
                    end else if (scan_code_q == 8'hF0) begin
                        dec_state_d = D_F0;
                    end else begin
                        m           = key_map(1'b0, scan_code_q);
                        keys_d      = keys_q | m;
                        key_press_d = m & ~keys_q;
                    end
                end
                D_E0: begin
                    if (scan_code_q == 8'hF0) begin
                        dec_state_d = D_E0F0;
                    end else begin
                        m           = key_map(1'b1, scan_code_q);
                        keys_d      = keys_q | m;
                        key_press_d = m & ~keys_q;
                        dec_state_d = D_IDLE;
                    end
                end
                D_F0: begin
                    keys_d      = keys_q & ~key_map(1'b0, scan_code_q);
                    dec_state_d = D_IDLE;
                end
                D_E0F0: begin
                    keys_d      = keys_q & ~key_map(1'b1, scan_code_q);
                    dec_state_d = D_IDLE;
                end
                default: dec_state_d = D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            fall_q       <= 1'b0;
            data_smp_q   <= 1'b1;
            rx_state_q   <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            dec_state_q  <= D_IDLE;
            keys_q       <= 5'b00000;
            key_press_q  <= 5'b00000;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            data_s1_q    <= ps2_data;
            data_s2_q    <= data_s1_q;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            fall_q       <= fall_d;
            data_smp_q   <= data_smp_d;
            rx_state_q   <= rx_state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            scan_code_q  <= scan_code_d;
            scan_valid_q <= scan_valid_d;
            frame_err_q  <= frame_err_d;
            dec_state_q  <= dec_state_d;
            keys_q       <= keys_d;
            key_press_q  <= key_press_d;
        end
    end

    assign keys       = keys_q;
    assign key_press  = key_press_q;
    assign scan_code  = scan_code_q;
    assign scan_valid = scan_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1500;
    localparam int HALF       = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [4:0] keys;
    logic [4:0] key_press;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keys      (keys),
        .key_press (key_press),
        .scan_code (scan_code),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_lat = 0;

    logic [7:0] sb_q[$];
    logic [7:0] obs_q[$];
    int fe_cnt = 0;
    int kp_cnt[5] = '{0, 0, 0, 0, 0};
    int fe_base = 0;
    int kp_base[5] = '{0, 0, 0, 0, 0};

    always @(negedge clk) begin
        if (rst_n) begin
            if (scan_valid) obs_q.push_back(scan_code);
            if (frame_err) fe_cnt = fe_cnt + 1;
            for (int i = 0; i < 5; i++) begin
                if (key_press[i]) kp_cnt[i] = kp_cnt[i] + 1;
            end
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF / 2) @(negedge clk);
            if (glitch && (i == 3 || i == 6)) begin
                ps2_clk = 1'b0;
                @(negedge clk);
                ps2_clk = 1'b1;
            end
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) begin
                last_lat = 0;
                for (int k = 1; k <= HALF; k++) begin
                    @(negedge clk);
                    if (scan_valid && last_lat == 0) last_lat = k;
                end
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        sb_q.push_back(b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic snap();
        fe_base = fe_cnt;
        for (int i = 0; i < 5; i++) kp_base[i] = kp_cnt[i];
    endtask

    task automatic check_scan(input string name);
        checks++;
        if (obs_q.size() !== sb_q.size()) begin
            errors++;
            $display("FAIL %s scan_valid count: got %0d expected %0d", name, obs_q.size(), sb_q.size());
        end
        while (obs_q.size() > 0 && sb_q.size() > 0) begin
            logic [7:0] got, exp;
            got = obs_q.pop_front();
            exp = sb_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s scan_code: got %h expected %h", name, got, exp);
            end
        end
        obs_q.delete();
        sb_q.delete();
    endtask

    task automatic check_keys(input string name, input logic [4:0] exp);
        checks++;
        if (keys !== exp) begin
            errors++;
            $display("FAIL %s keys: got %b expected %b", name, keys, exp);
        end
    endtask

    task automatic check_pulses(input string name, input logic [4:0] exp);
        logic [5:0] got;
        got = 6'b0;
        for (int i = 0; i < 5; i++) begin
            if (kp_cnt[i] - kp_base[i] == 1) got[i] = 1'b1;
            else if (kp_cnt[i] - kp_base[i] > 1) got[5] = 1'b1;
        end
        checks++;
        if (got !== {1'b0, exp}) begin
            errors++;
            $display("FAIL %s key_press pulses: got %b (bit5=over-long) expected %b", name, got, {1'b0, exp});
        end
    endtask

    task automatic check_fe(input string name, input int exp);
        checks++;
        if (fe_cnt - fe_base !== exp) begin
            errors++;
            $display("FAIL %s frame_err pulses: got %0d expected %0d", name, fe_cnt - fe_base, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({keys, key_press, scan_code, scan_valid, frame_err} !== 20'h0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", {keys, key_press, scan_code, scan_valid, frame_err});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if ({keys, key_press, scan_code, scan_valid, frame_err} !== 20'h0) begin
            errors++;
            $display("FAIL post_reset idle: got %h expected 0", {keys, key_press, scan_code, scan_valid, frame_err});
        end
    endtask

    task automatic test_make_up();
        snap();
        send_good(8'hE0);
        checks++;
        if (last_lat !== FILTER_LEN + 3) begin
            errors++;
            $display("FAIL latency stop_edge_to_scan_valid: got %0d expected %0d", last_lat, FILTER_LEN + 3);
        end
        send_good(8'h75);
        check_scan("make_up");
        check_keys("make_up", 5'b00001);
        check_pulses("make_up", 5'b00001);
    endtask

    task automatic test_typematic_break();
        snap();
        send_good(8'hE0); send_good(8'h75);
        send_good(8'hE0); send_good(8'h75);
        check_keys("repeat", 5'b00001);
        check_pulses("repeat", 5'b00000);
        send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
        check_scan("repeat_break");
        check_keys("break_up", 5'b00000);
    endtask

    task automatic test_multi_key();
        snap();
        send_good(8'h29);
        check_keys("space", 5'b10000);
        send_good(8'hE0); send_good(8'h6B);
        check_keys("space_left", 5'b10010);
        send_good(8'hF0); send_good(8'h29);
        check_keys("left_only", 5'b00010);
        check_scan("multi_key");
        check_pulses("multi_key", 5'b10010);
    endtask

    task automatic test_parity_and_unmapped();
        snap();
        send_frame(8'h75, 1'b1, 1'b0, 11);
        check_fe("bad_parity", 1);
        check_scan("bad_parity");
        check_keys("bad_parity", 5'b00010);
        send_good(8'hE0); send_good(8'h72);
        check_keys("down", 5'b01010);
        snap();
        send_good(8'h75);
        send_good(8'hE1);
        send_good(8'hE0); send_good(8'hF0); send_good(8'h74);
        check_scan("unmapped");
        check_keys("unmapped_no_change", 5'b01010);
        check_pulses("unmapped", 5'b00000);
    endtask

    task automatic test_timeout();
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 4);
        repeat (TIMEOUT + 200) @(negedge clk);
        check_fe("timeout", 1);
        check_scan("timeout");
        send_good(8'h29);
        check_scan("after_timeout");
        check_keys("after_timeout", 5'b11010);
        check_pulses("after_timeout", 5'b10000);
    endtask

    task automatic test_prefix_error();
        snap();
        send_good(8'hE0);
        send_frame(8'h11, 1'b1, 1'b0, 11);
        send_good(8'h74);
        check_fe("prefix_err", 1);
        check_scan("prefix_err");
        check_keys("prefix_err", 5'b11110);
    endtask

    task automatic test_glitch_and_reset();
        snap();
        sb_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        sb_q.push_back(8'h29);
        send_frame(8'h29, 1'b0, 1'b1, 11);
        check_fe("glitch", 0);
        check_scan("glitch");
        check_keys("glitch_break_space", 5'b01110);
        send_frame(8'h6B, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({keys, key_press, scan_code, scan_valid, frame_err} !== 20'h0) begin
            errors++;
            $display("FAIL midframe_reset outputs: got %h expected 0", {keys, key_press, scan_code, scan_valid, frame_err});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        snap();
        send_good(8'hE0); send_good(8'h75);
        check_scan("after_reset");
        check_keys("after_reset", 5'b00001);
        check_pulses("after_reset", 5'b00001);
        check_fe("after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_make_up();
        test_typematic_break();
        test_multi_key();
        test_parity_and_unmapped();
        test_timeout();
        test_prefix_error();
        test_glitch_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
